// File: rtl/bcd_to_bin_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin_seq_if
//  Description : Start/done handshake and data bundle for the sequential
//                BCD-to-binary converter. The master drives the request and
//                the packed digits; the slave (converter) returns status and
//                the result.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  sign_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W:0]        bin_out;

    modport master (
        output start, bcd_in, sign_in,
        input  busy, done, err, bin_out
    );

    modport slave (
        input  start, bcd_in, sign_in,
        output busy, done, err, bin_out
    );
endinterface
`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin_seq
//  Description : Sequential BCD-to-binary converter using reverse double
//                dabble (shift right one bit, then subtract 3 from every BCD
//                nibble that is >= 8). One shift per clock, BIN_W shifts per
//                conversion. Digits above 9 are flagged through err.
//                Optional macro BCD_TO_BIN_SIGNED_EN: when defined, the
//                captured sign_in selects a two's complement result.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  wire logic         clk,
    input  wire logic         rst,
    bcd_to_bin_seq_if.slave   bus
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_tot_w = c_bcd_w + BIN_W;
    localparam int c_cnt_w = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(BIN_W - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_fault = 2'd2;

    logic [1:0]          r_state_q;
    logic [c_bcd_w-1:0]  r_bcd_q;
    logic [BIN_W-1:0]    r_bin_q;
    logic [c_cnt_w-1:0]  r_cnt_q;
    logic                r_busy_q;
    logic                r_done_q;
    logic                r_err_q;
    logic [BIN_W:0]      r_bin_out_q;

    logic [c_tot_w-1:0]  w_shift;
    logic [c_bcd_w-1:0]  w_bcd_d;
    logic [BIN_W-1:0]    w_bin_d;
    logic [DIGITS-1:0]   w_digit_bad;
    logic                w_any_bad;
    logic [BIN_W:0]      w_result;

    // Working register shifted right by one; the bit leaving bcd_q enters bin_q.
    assign w_shift = {r_bcd_q, r_bin_q} >> 1;
    assign w_bin_d = w_shift[BIN_W-1:0];

    // Per-nibble correction after the shift, plus invalid-digit detection on capture.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_nib;
            assign w_nib = w_shift[BIN_W + 4*gi +: 4];
            assign w_bcd_d[4*gi +: 4] = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
            assign w_digit_bad[gi]    = (bus.bcd_in[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign w_any_bad = |w_digit_bad;

`ifdef BCD_TO_BIN_SIGNED_EN
    logic r_sign_q;

    // Sign captured with the digits so later sign_in changes cannot affect the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign_q <= 1'b0;
        end else if (r_state_q == c_st_idle && bus.start) begin
            r_sign_q <= bus.sign_in;
        end
    end

    // Negation folded into the done edge; -0 naturally yields all zeros.
    assign w_result = r_sign_q ? (~{1'b0, w_bin_d} + {{BIN_W{1'b0}}, 1'b1})
                               : {1'b0, w_bin_d};
`else
    logic w_unused_sign;

    assign w_unused_sign = bus.sign_in;
    assign w_result      = {1'b0, w_bin_d};
`endif

    // Main control FSM: capture in IDLE, BIN_W shift iterations, one-edge FAULT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= c_st_idle;
            r_bcd_q     <= '0;
            r_bin_q     <= '0;
            r_cnt_q     <= '0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_err_q     <= 1'b0;
            r_bin_out_q <= '0;
        end else begin
            r_done_q <= 1'b0;
            case (r_state_q)
                c_st_idle: begin
                    if (bus.start) begin
                        r_bcd_q <= bus.bcd_in;
                        r_bin_q <= '0;
                        r_cnt_q <= '0;
                        if (w_any_bad) begin
                            r_state_q <= c_st_fault;
                        end else begin
                            r_state_q <= c_st_shift;
                            r_busy_q  <= 1'b1;
                        end
                    end
                end
                c_st_shift: begin
                    r_bcd_q <= w_bcd_d;
                    r_bin_q <= w_bin_d;
                    r_cnt_q <= r_cnt_q + 1'b1;
                    // This edge performs the final shift, so publish its result directly.
                    if (r_cnt_q == c_last_cnt) begin
                        r_state_q   <= c_st_idle;
                        r_bin_out_q <= w_result;
                        r_done_q    <= 1'b1;
                        r_err_q     <= 1'b0;
                        r_busy_q    <= 1'b0;
                    end
                end
                c_st_fault: begin
                    r_state_q   <= c_st_idle;
                    r_bin_out_q <= '0;
                    r_done_q    <= 1'b1;
                    r_err_q     <= 1'b1;
                end
                default: begin
                    r_state_q <= c_st_idle;
                    r_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy_q;
    assign bus.done    = r_done_q;
    assign bus.err     = r_err_q;
    assign bus.bin_out = r_bin_out_q;

endmodule
`default_nettype wire
